bcd_scan_decoder: RTL
=====================

BCD_SCAN_DECODER -- requirements
Module: bcd_scan_decoder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits (legal range 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 1000, clock cycles each digit is displayed (legal minimum 2).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  producer offers a new BCD word.
REQ-006 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-007 SHALL have port in_bcd  input  4*DIGITS  packed BCD word; nibble 0 is the least significant digit.
REQ-008 SHALL have port err_clr  input  1  clears the sticky error flag.
REQ-009 SHALL have port dig_sel  output  DIGITS  one-hot, active-high select of the digit now driven.
REQ-010 SHALL have port seg_out  output  10  one-hot decode of the selected digit.
REQ-011 SHALL have port err  output  1  sticky flag for an invalid nibble.

Function
REQ-012 SHALL implement a two-state FSM:
- IDLE: nothing loaded; dig_sel=0, seg_out=0.
- SCAN: loaded value is being scanned.
REQ-013 SHALL assert in_ready in IDLE, and in SCAN only on the last dwell cycle of the last digit (frame end).
REQ-014 SHALL capture in_bcd into a shadow register when in_valid && in_ready, then enter or remain in SCAN.
REQ-015 SHALL drive dig_sel=digit 0 and seg_out with valid data on the cycle after acceptance; one-cycle latency, registered outputs.
REQ-016 SHALL hold each digit for SCAN_DIV cycles using a dwell counter 0..SCAN_DIV-1, then advance the digit index 0..DIGITS-1, wrapping to 0.
REQ-017 SHALL keep scanning the current shadow value at frame end when no new word is offered.
REQ-018 SHALL decode a nibble 0..9 to seg_out bit n set; nibble 10..15 SHALL give seg_out=0.
REQ-019 SHALL set err on an accepted word containing any nibble >9; err SHALL stay set until err_clr; a set and err_clr in the same cycle SHALL leave err=1.
REQ-020 SHALL start a new word at digit 0 with the dwell counter at 0, regardless of prior position.

Reset
REQ-021 SHALL, while rst=1, force: FSM=IDLE, shadow=0, counters=0, dig_sel=0, seg_out=0, err=0, in_ready=0.
REQ-022 SHALL abandon any scan in progress when rst is asserted mid-scan; in_ready=1 on the first cycle after deassertion.

Configuration
REQ-023 SHALL support macro BCD_LZ_BLANK_EN:
- Defined: zero digits above the most significant nonzero digit are blanked (seg_out=0, dig_sel still asserted); digit 0 is never blanked.
- Undefined: every digit is decoded normally.

Structure
REQ-024 SHALL place the following in shared package bcd_pkg:
- BCD_W=4 and ONEHOT_W=10;
- the BCD digit and one-hot typedefs;
- the FSM state enumeration.
REQ-025 SHALL instantiate sub-module bcd_digit_dec, a combinational nibble-to-10-bit one-hot decoder with zero output for nibbles >9.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-026 SHALL cover: reset, load 16'h1234 -> next cycle dig_sel=4'b0001, seg_out=10'h010; 4 cycles later dig_sel=4'b0010, seg_out=10'h008; wraps to digit 0 after 16 cycles.
REQ-027 SHALL cover: in_valid held with 16'h0009 during a scan -> in_ready=1 only on frame cycle 15; new value shown from the next frame's digit 0 with seg_out=10'h200.
REQ-028 SHALL cover: load 16'h12A4 -> err=1 and digit 1 seg_out=0; err_clr pulse -> err=0 next cycle; err_clr coincident with a new bad word -> err stays 1.
REQ-029 SHALL cover: load 16'h0050:
- with BCD_LZ_BLANK_EN: digits 3 and 2 give seg_out=0, digit 1 gives 10'h020, digit 0 gives 10'h001;
- without it: digit 3 gives 10'h001.
REQ-030 SHALL cover: rst asserted mid-digit 2 -> dig_sel=0 and seg_out=0 immediately; after release, FSM=IDLE and in_ready=1.
REQ-031 SHALL cover: DIGITS=1 -> dig_sel constant 1'b1 and in_ready high on every 4th cycle in SCAN.

Source files
------------

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared widths, digit/one-hot types and scan FSM states
// Purpose: common definitions for bcd_scan_decoder and bcd_digit_dec.
// Ports: none (package).
package bcd_pkg;

  localparam int BCD_W    = 4;
  localparam int ONEHOT_W = 10;

  typedef logic [BCD_W-1:0]    bcd_digit_t;
  typedef logic [ONEHOT_W-1:0] onehot_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // A nibble outside 0..9 is not a legal BCD digit.
  function automatic logic bcd_invalid(input bcd_digit_t d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// rtl/bcd_digit_dec.sv - combinational BCD nibble to 10-bit one-hot decoder
// Purpose: nibble n in 0..9 sets seg bit n; nibbles 10..15 give all zeros.
// Ports:
//   digit - input  BCD_W     nibble to decode
//   seg   - output ONEHOT_W  one-hot decode, zero for illegal nibbles
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0]    digit,
  output logic [ONEHOT_W-1:0] seg
);

  always_comb begin
    seg = '0;
    if (!bcd_invalid(digit)) begin
      seg = ONEHOT_W'(1) << digit;
    end
  end

endmodule

// File: rtl/bcd_scan_decoder.sv
// rtl/bcd_scan_decoder.sv - multiplexed BCD display scanner with one-hot digit decode
// Purpose: captures a packed BCD word and scans its digits, SCAN_DIV cycles each.
// Optional feature macro: BCD_LZ_BLANK_EN (leading-zero blanking; digit 0 never blanked).
// Ports:
//   clk      - input  1            rising-edge clock
//   rst      - input  1            asynchronous active-high reset
//   in_valid - input  1            producer offers a new word
//   in_ready - output 1            word accepted this cycle when in_valid
//   in_bcd   - input  4*DIGITS     packed BCD word, nibble 0 least significant
//   err_clr  - input  1            clears sticky err
//   dig_sel  - output DIGITS       one-hot active-high digit select
//   seg_out  - output 10           one-hot decode of the selected digit
//   err      - output 1            sticky flag: accepted word had a nibble > 9
module bcd_scan_decoder
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BCD_W*DIGITS-1:0]   in_bcd,
  input  logic                      err_clr,
  output logic [DIGITS-1:0]         dig_sel,
  output logic [ONEHOT_W-1:0]       seg_out,
  output logic                      err
);

  localparam int DIG_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam logic [DIG_W-1:0]   LAST_DIG   = DIG_W'(DIGITS - 1);
  localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(SCAN_DIV - 1);

  state_t                    state_q, state_d;
  logic [BCD_W*DIGITS-1:0]   shadow_q, shadow_d;
  logic [DIG_W-1:0]          digit_q, digit_d;
  logic [DWELL_W-1:0]        dwell_q, dwell_d;
  logic [DIGITS-1:0]         dig_sel_q, dig_sel_d;
  logic [ONEHOT_W-1:0]       seg_out_q, seg_out_d;
  logic                      err_q, err_d;

  logic                      frame_end;
  logic                      ready_int;
  logic                      accept;
  logic                      word_bad;
  logic [BCD_W-1:0]          cur_nibble;
  logic [ONEHOT_W-1:0]       dec_seg;
  logic                      blank;

  // Acceptance handshake: a new word is only taken between frames.
  always_comb begin
    frame_end = (state_q == ST_SCAN) && (digit_q == LAST_DIG) && (dwell_q == LAST_DWELL);
    ready_int = (state_q == ST_IDLE) || frame_end;
    accept    = in_valid && ready_int;
  end

  always_comb begin
    word_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_invalid(in_bcd[i*BCD_W +: BCD_W])) begin
        word_bad = 1'b1;
      end
    end
  end

  // Next-state: FSM, shadow word, digit index and dwell counter.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    digit_d  = digit_q;
    dwell_d  = dwell_q;
    if (accept) begin
      state_d  = ST_SCAN;
      shadow_d = in_bcd;
      digit_d  = '0;
      dwell_d  = '0;
    end else if (state_q == ST_SCAN) begin
      if (dwell_q == LAST_DWELL) begin
        dwell_d = '0;
        digit_d = (digit_q == LAST_DIG) ? '0 : digit_q + DIG_W'(1);
      end else begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end
  end

  // Setting wins over clearing when both happen in the same cycle.
  always_comb begin
    err_d = err_q;
    if (accept && word_bad) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Outputs are computed from next-state values so the registered outputs
  // show digit 0 of a new word on the cycle right after acceptance.
  always_comb begin
    cur_nibble = shadow_d[BCD_W*digit_d +: BCD_W];
  end

  bcd_digit_dec u_dec (
    .digit (cur_nibble),
    .seg   (dec_seg)
  );

`ifdef BCD_LZ_BLANK_EN
  logic [BCD_W*DIGITS-1:0] upper_digits;
  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    upper_digits = shadow_d >> (BCD_W * digit_d);
    blank        = (digit_d != '0) && (upper_digits == '0);
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  always_comb begin
    dig_sel_d = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_sel_d[i] = (state_d == ST_SCAN) && (digit_d == DIG_W'(i));
    end
    seg_out_d = ((state_d == ST_SCAN) && !blank) ? dec_seg : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      digit_q   <= '0;
      dwell_q   <= '0;
      dig_sel_q <= '0;
      seg_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      digit_q   <= digit_d;
      dwell_q   <= dwell_d;
      dig_sel_q <= dig_sel_d;
      seg_out_q <= seg_out_d;
      err_q     <= err_d;
    end
  end

  // in_ready is held low while reset is applied, independent of the clock.
  assign in_ready = ready_int && !rst;
  assign dig_sel  = dig_sel_q;
  assign seg_out  = seg_out_q;
  assign err      = err_q;

endmodule
